conv_encoder_framer: RTL

// - Rate-1/2, K=4 (8-state) convolutional encoder feeding the Viterbi decoder's d_in[1:0] input.
// - Accepts a serial bit stream over a valid/ready handshake and frames it into FRAME_LEN data bits.
// - Appends K-1=3 zero tail bits per frame, so each frame ends in state 000.
// - Default frame = 1024 symbols, one trellis memory bank.

---
 rtl/conv_encoder_framer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=4 convolutional encoder that frames a serial bit stream into FRAME_LEN data bits
// plus three zero tail bits. Optional macro ERR_INJECT_EN XORs err_inject into every emitted symbol.
module conv_encoder_framer #(
    parameter int         FRAME_LEN = 1021,
    parameter logic [3:0] G0        = 4'b1101,
    parameter logic [3:0] G1        = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] d_out,
    output logic       d_out_valid,
    output logic       frame_sop,
    output logic       frame_eop,
    output logic       enc_active,
    input  logic [1:0] err_inject,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [1:0]         tail_cnt;

    logic               accept;
    logic               enc_bit;
    logic [3:0]         vec;
    logic [1:0]         code;
    logic [1:0]         sym;

    // Handshake: a bit transfers on any rising edge where din_valid and din_ready are both high;
    // din_ready is a register driven from the next FSM state, so it never depends on din_valid.
    assign accept  = din_valid & din_ready;
    assign enc_bit = (state == TAIL) ? 1'b0 : din;
    assign vec     = {enc_bit, sr};
    assign code    = {^(vec & G0), ^(vec & G1)};

`ifdef ERR_INJECT_EN
    assign sym = code ^ err_inject;
`else
    logic unused_err_inject;
    assign unused_err_inject = ^err_inject;
    assign sym = code;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= 3'b000;
            bit_cnt     <= '0;
            tail_cnt    <= 2'd0;
            din_ready   <= 1'b0;
            d_out       <= 2'b00;
            d_out_valid <= 1'b0;
            frame_sop   <= 1'b0;
            frame_eop   <= 1'b0;
            enc_active  <= 1'b0;
        end else begin
            d_out_valid <= 1'b0;
            frame_sop   <= 1'b0;
            frame_eop   <= 1'b0;
            case (state)
                IDLE: begin
                    din_ready  <= 1'b1;
                    enc_active <= accept;
                    bit_cnt    <= '0;
                    tail_cnt   <= 2'd0;
                    if (accept) begin
                        d_out       <= sym;
                        d_out_valid <= 1'b1;
                        frame_sop   <= 1'b1;
                        sr          <= {enc_bit, sr[2:1]};
                        bit_cnt     <= CNT_W'(1);
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        d_out       <= sym;
                        d_out_valid <= 1'b1;
                        sr          <= {enc_bit, sr[2:1]};
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            state     <= TAIL;
                            din_ready <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    // Zero bits flush the register; after the third one sr is back to 000.
                    d_out       <= sym;
                    d_out_valid <= 1'b1;
                    sr          <= {enc_bit, sr[2:1]};
                    tail_cnt    <= tail_cnt + 2'd1;
                    if (tail_cnt == 2'd2) begin
                        frame_eop <= 1'b1;
                        state     <= IDLE;
                        din_ready <= 1'b1;
                        bit_cnt   <= '0;
                        tail_cnt  <= 2'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    din_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
